vga_rect_plotter: RTL and testbench

//  Parametrised pixel-stream engine driving the VGA pixel port (x, y, colour, plot).

---
 rtl/vga_rect_plotter.sv | 139 +++++++++++++
 tb/tb_vga_rect_plotter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/vga_rect_plotter.sv
// Raster pixel engine for the VGA adapter port: draws one filled rectangle or a
// full-screen clear per command, one pixel per clock, with clipping and pause.
module vga_rect_plotter #(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOUR_W  = 3,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int BG_COLOUR = 0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      w,
  input  logic [Y_W-1:0]      h,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                pause,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state, next_state;

  logic [X_W-1:0]      x0_q, w_q, cx;
  logic [Y_W-1:0]      y0_q, h_q, cy;
  logic [COLOUR_W-1:0] col_q;
  logic                fin;

  logic [X_W-1:0]      eff_x0, eff_w, s_x0, s_w, s_cx;
  logic [Y_W-1:0]      eff_y0, eff_h, s_y0, s_h, s_cy;
  logic [COLOUR_W-1:0] eff_col, s_col;
  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;
  logic                accept, empty, emit, vis, row_end, col_end;

  always_comb begin
    if (mode) begin
      eff_x0  = '0;
      eff_y0  = '0;
      eff_w   = X_W'(SCREEN_W);
      eff_h   = Y_W'(SCREEN_H);
      eff_col = COLOUR_W'(BG_COLOUR);
    end else begin
      eff_x0  = x0;
      eff_y0  = y0;
      eff_w   = w;
      eff_h   = h;
      eff_col = colour_in;
    end
  end

  // The first pixel is produced on the accepting edge straight from the
  // command inputs, so DRAW lasts exactly w*h unpaused cycles.
  always_comb begin
    accept  = (state == IDLE) && start;
    empty   = (eff_w == '0) || (eff_h == '0);
    s_x0    = (state == IDLE) ? eff_x0  : x0_q;
    s_y0    = (state == IDLE) ? eff_y0  : y0_q;
    s_w     = (state == IDLE) ? eff_w   : w_q;
    s_h     = (state == IDLE) ? eff_h   : h_q;
    s_col   = (state == IDLE) ? eff_col : col_q;
    s_cx    = (state == IDLE) ? '0 : cx;
    s_cy    = (state == IDLE) ? '0 : cy;
    emit    = (accept && !empty) || ((state == DRAW) && !pause && !fin);
    sum_x   = {1'b0, s_x0} + {1'b0, s_cx};
    sum_y   = {1'b0, s_y0} + {1'b0, s_cy};
    vis     = (sum_x < SCR_W) && (sum_y < SCR_H);
    row_end = (s_cx == s_w - 1'b1);
    col_end = (s_cy == s_h - 1'b1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = empty ? DONE : DRAW;
      DRAW: if (!pause && fin) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRAW);
    done = (state == DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x0_q   <= '0;
      y0_q   <= '0;
      w_q    <= '0;
      h_q    <= '0;
      col_q  <= '0;
      cx     <= '0;
      cy     <= '0;
      fin    <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      if (accept) begin
        x0_q  <= eff_x0;
        y0_q  <= eff_y0;
        w_q   <= eff_w;
        h_q   <= eff_h;
        col_q <= eff_col;
      end
      if (emit) begin
        x      <= sum_x[X_W-1:0];
        y      <= sum_y[Y_W-1:0];
        colour <= s_col;
        plot   <= vis;
        fin    <= row_end && col_end;
        cx     <= row_end ? '0 : s_cx + 1'b1;
        cy     <= row_end ? s_cy + 1'b1 : s_cy;
      end else begin
        plot   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Directed bench for vga_rect_plotter: fill, clipping, clear, empty, pause and
// mid-draw abort, checked against a raster model built from the command.
module tb_vga_rect_plotter;

  logic       CLOCK_50 = 1'b0;
  logic       reset, start, mode, pause;
  logic [7:0] x0, w, x;
  logic [6:0] y0, h, y;
  logic [2:0] colour_in, colour;
  logic       plot, busy, done;

  int checks = 0;
  int errors = 0;

  vga_rect_plotter #(
    .X_W(8), .Y_W(7), .COLOUR_W(3), .SCREEN_W(160), .SCREEN_H(120), .BG_COLOUR(0)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .mode(mode),
    .x0(x0), .y0(y0), .w(w), .h(h), .colour_in(colour_in), .pause(pause),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_colour"}, 32'(colour), 0);
    check({tag, "_plot"}, 32'(plot), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // Issues one command and follows it to completion. pause_at/ghost_at/reset_at
  // are DRAW-cycle indices (-1 = unused).
  task automatic run(input string tag, input logic m, input int x0v, input int y0v,
                     input int wv, input int hv, input int colv, input int pause_at,
                     input int pause_len, input int ghost_at, input int reset_at);
    int ex[$], ey[$];
    int ex0, ey0, ew, eh, ecol, idx, draw, dones, done_cyc, bad;
    ex0 = m ? 0 : x0v;  ey0 = m ? 0 : y0v;
    ew  = m ? 160 : wv; eh  = m ? 120 : hv;
    ecol = m ? 0 : colv;
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++)
        if (ex0 + c < 160 && ey0 + r < 120) begin
          ex.push_back(ex0 + c);
          ey.push_back(ey0 + r);
        end
    start = 1'b1; mode = m;
    x0 = 8'(x0v); y0 = 7'(y0v); w = 8'(wv); h = 7'(hv); colour_in = 3'(colv);
    tick();
    start = 1'b0; mode = 1'b0;
    // scramble the command inputs to show the latched copy is used
    x0 = 8'hFF; y0 = 7'h7F; w = 8'd1; h = 7'd1; colour_in = 3'd5;
    idx = 0; draw = 0; dones = 0; done_cyc = 0;
    for (int t = 0; t < ew * eh + pause_len + 8; t++) begin
      pause = 1'b0;
      start = 1'b0;
      if (busy) begin
        if (draw == reset_at) begin
          reset = 1'b1;
          tick();
          check_quiet({tag, "_abort"});
          reset = 1'b0;
          bad = 0;
          for (int k = 0; k < 10; k++) begin
            tick();
            if (plot || done || busy) bad++;
          end
          check({tag, "_abort_silent"}, 32'(bad), 0);
          return;
        end
        if (draw >= pause_at && draw < pause_at + pause_len) pause = 1'b1;
        if (draw == ghost_at) start = 1'b1;
        draw++;
      end
      if (plot) begin
        if (idx < ex.size()) begin
          check($sformatf("%s_x%0d", tag, idx), 32'(x), 32'(ex[idx]));
          check($sformatf("%s_y%0d", tag, idx), 32'(y), 32'(ey[idx]));
          check($sformatf("%s_c%0d", tag, idx), 32'(colour), 32'(ecol));
        end else begin
          check({tag, "_extra_plot"}, 1, 0);
        end
        idx++;
      end
      if (done) begin
        dones++;
        if (done_cyc == 0) done_cyc = t + 1;
        check({tag, "_done_busy"}, 32'(busy), 0);
      end
      tick();
    end
    pause = 1'b0;
    start = 1'b0;
    check({tag, "_plots"}, 32'(idx), 32'(ex.size()));
    check({tag, "_draw_cycles"}, 32'(draw), 32'(ew * eh + pause_len));
    check({tag, "_dones"}, 32'(dones), 1);
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(ew * eh + pause_len + 1));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; pause = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; colour_in = '0;
    repeat (2) tick();
    check_quiet("reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("idle");
    end
    // pause in IDLE must not matter
    pause = 1'b1;
    tick();
    check({"idle_pause_busy"}, 32'(busy), 0);

    run("fill",   1'b0, 10, 5, 3, 2, 4, -1, 0, -1, -1);
    run("clipx",  1'b0, 158, 0, 4, 1, 5, -1, 0, -1, -1);
    run("clipy",  1'b0, 50, 118, 2, 4, 2, -1, 0, -1, -1);
    run("clear",  1'b1, 20, 20, 5, 5, 7, -1, 0, 100, -1);
    run("emptyw", 1'b0, 3, 3, 0, 5, 2, -1, 0, -1, -1);
    run("emptyh", 1'b0, 3, 3, 5, 0, 2, -1, 0, -1, -1);
    run("single", 1'b0, 159, 119, 1, 1, 6, -1, 0, -1, -1);
    run("pause",  1'b0, 20, 30, 4, 4, 6, 6, 3, -1, -1);
    run("abort",  1'b0, 20, 30, 4, 4, 6, -1, 0, -1, 5);
    run("after",  1'b0, 1, 2, 2, 2, 3, -1, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
